// File: rtl/timer_mux_pkg.sv
// timer_mux shared types and constants.
// State, op encoding, CLINT offsets, idle compare value.
package timer_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_HI_MAX,
    WR_LO,
    WR_HI
  } state_e;

  typedef enum logic {
    OP_ARM    = 1'b0,
    OP_CANCEL = 1'b1
  } op_e;

  localparam logic [15:0] MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] MTIMECMP_HI_OFF = 16'h4004;

  localparam logic [63:0] NO_DEADLINE = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_mux_min.sv
// timer_mux_min: earliest deadline over armed slots.
// Ties keep the lowest index; min_val is NO_DEADLINE when none armed.
module timer_mux_min
  import timer_mux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] armed,
  input  logic [63:0]  deadline [N],
  output logic [63:0]  min_val,
  output logic         valid
);

  always_comb begin
    min_val = NO_DEADLINE;
    valid   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (armed[i] && (!valid || deadline[i] < min_val)) begin
        min_val = deadline[i];
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_mux.sv
// timer_mux: virtual timers multiplexed onto CLINT mtimecmp.
// TIMER_MUX_SAFE_UPDATE_EN parks mtimecmp hi at max before lo/hi writes.
module timer_mux
  import timer_mux_pkg::*;
#(
  parameter int          NUM_TIMERS = 4,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_valid_i,
  input  logic                          cfg_op_i,
  input  logic [$clog2(NUM_TIMERS)-1:0] cfg_id_i,
  input  logic [63:0]                   cfg_deadline_i,
  input  logic [63:0]                   mtime_i,
  input  logic [NUM_TIMERS-1:0]         expired_ack_i,
  output logic [NUM_TIMERS-1:0]         expired_o,
  output logic                          irq_o,
  output logic                          busy_o,
  output logic [31:0]                   wbm_adr_o,
  output logic [31:0]                   wbm_dat_o,
  output logic                          wbm_we_o,
  output logic [3:0]                    wbm_sel_o,
  output logic                          wbm_cyc_o,
  output logic                          wbm_stb_o,
  input  logic                          wbm_ack_i
);

  localparam int IW = $clog2(NUM_TIMERS);
  localparam logic [31:0] ADR_LO = CLINT_BASE + 32'(MTIMECMP_LO_OFF);
  localparam logic [31:0] ADR_HI = CLINT_BASE + 32'(MTIMECMP_HI_OFF);

  logic [NUM_TIMERS-1:0] armed_q, expired_q, cmd, hit;
  logic [63:0]           deadline_q [NUM_TIMERS];
  logic [63:0]           min_val, target;
  logic                  min_valid, arm;

  assign arm = (cfg_op_i == 1'(OP_ARM));

  // A command on a slot masks its expiry in the same cycle.
  always_comb begin
    cmd = '0;
    hit = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cmd[i] = cfg_valid_i && (cfg_id_i == IW'(i));
      hit[i] = armed_q[i] && (mtime_i >= deadline_q[i]) && !cmd[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      armed_q   <= '0;
      expired_q <= '0;
      for (int i = 0; i < NUM_TIMERS; i++)
        deadline_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (cmd[i]) begin
          armed_q[i] <= arm;
          if (arm) deadline_q[i] <= cfg_deadline_i;
        end else if (hit[i]) begin
          armed_q[i] <= 1'b0;
        end
        if (hit[i])                expired_q[i] <= 1'b1;
        else if (expired_ack_i[i]) expired_q[i] <= 1'b0;
      end
    end
  end

  timer_mux_min #(.N(NUM_TIMERS)) u_min (
    .armed    (armed_q),
    .deadline (deadline_q),
    .min_val  (min_val),
    .valid    (min_valid)
  );

  assign target = min_valid ? min_val : NO_DEADLINE;

  state_e      state_q, state_d;
  logic [63:0] snap_q, snap_d, prog_q, prog_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic        cyc_q, cyc_d, busy_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      snap_q  <= '0;
      prog_q  <= NO_DEADLINE;
      adr_q   <= '0;
      dat_q   <= '0;
      cyc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      prog_q  <= prog_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      cyc_q   <= cyc_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // cyc low on entry to a write state is the 1-cycle gap after an ack.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    prog_d  = prog_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        if (target != prog_q) begin
          snap_d = target;
          cyc_d  = 1'b1;
`ifdef TIMER_MUX_SAFE_UPDATE_EN
          state_d = WR_HI_MAX;
          adr_d   = ADR_HI;
          dat_d   = 32'hFFFF_FFFF;
`else
          state_d = WR_LO;
          adr_d   = ADR_LO;
          dat_d   = target[31:0];
`endif
        end
      end
`ifdef TIMER_MUX_SAFE_UPDATE_EN
      WR_HI_MAX: begin
        if (cyc_q && wbm_ack_i) begin
          cyc_d   = 1'b0;
          state_d = WR_LO;
        end
      end
`endif
      WR_LO: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = ADR_LO;
          dat_d = snap_q[31:0];
        end else if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = ADR_HI;
          dat_d = snap_q[63:32];
        end else if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          prog_d  = snap_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign expired_o = expired_q;
  assign irq_o     = |expired_q;
  assign busy_o    = busy_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = cyc_q;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;

endmodule

// File: tb/tb_timer_mux.sv
// tb_timer_mux: self-checking bench for timer_mux.
// Expected bus sequences follow TIMER_MUX_SAFE_UPDATE_EN when defined.
module tb_timer_mux;
  import timer_mux_pkg::*;

  localparam int NT = 4;
  localparam logic [31:0] LO = 32'h0200_4000;
  localparam logic [31:0] HI = 32'h0200_4004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_op = 1'b0;
  logic [1:0]    cfg_id = '0;
  logic [63:0]   cfg_dl = '0;
  logic [63:0]   mtime = '0;
  logic [NT-1:0] exp_ack = '0;
  logic [NT-1:0] expired;
  logic          irq, busy, we, cyc, stb, ack;
  logic [31:0]   adr, dat;
  logic [3:0]    sel;

  timer_mux #(.NUM_TIMERS(NT), .CLINT_BASE(32'h0200_0000)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cfg_valid_i    (cfg_valid),
    .cfg_op_i       (cfg_op),
    .cfg_id_i       (cfg_id),
    .cfg_deadline_i (cfg_dl),
    .mtime_i        (mtime),
    .expired_ack_i  (exp_ack),
    .expired_o      (expired),
    .irq_o          (irq),
    .busy_o         (busy),
    .wbm_adr_o      (adr),
    .wbm_dat_o      (dat),
    .wbm_we_o       (we),
    .wbm_sel_o      (sel),
    .wbm_cyc_o      (cyc),
    .wbm_stb_o      (stb),
    .wbm_ack_i      (ack)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } wr_t;

  typedef struct {
    logic        v;
    logic        op;
    logic [1:0]  id;
    logic [63:0] dl;
    logic [63:0] mt;
    logic [3:0]  ack;
    logic [3:0]  ex;
  } step_t;

  // CLINT slave model: acks after lat wait cycles, logs every accepted write.
  wr_t         wlog[$];
  wr_t         ex[$];
  int unsigned lat = 0;
  int unsigned cnt = 0;
  int          cyc_cycles = 0;
  logic [31:0] clint_lo = 32'hFFFF_FFFF;
  logic [31:0] clint_hi = 32'hFFFF_FFFF;

  assign ack = cyc && stb && (cnt >= lat);

  always @(posedge clk) begin
    cnt <= (cyc && stb && !ack) ? cnt + 1 : 0;
    if (cyc) cyc_cycles <= cyc_cycles + 1;
    if (cyc && stb && ack) begin
      wlog.push_back('{adr, dat, we, sel});
      if (adr == LO) clint_lo <= dat;
      if (adr == HI) clint_hi <= dat;
    end
  end

  // Reference slot state.
  logic [NT-1:0] m_armed = '0;
  logic [NT-1:0] m_exp = '0;
  logic [63:0]   m_dl [NT];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [63:0] m_target();
    logic [63:0] t = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < NT; i++)
      if (m_armed[i] && m_dl[i] < t) t = m_dl[i];
    return t;
  endfunction

  function automatic wr_t w(logic [31:0] a, logic [31:0] d);
    return '{a, d, 1'b1, 4'hF};
  endfunction

  function automatic void push_seq(logic [63:0] v);
`ifdef TIMER_MUX_SAFE_UPDATE_EN
    ex.push_back(w(HI, 32'hFFFF_FFFF));
`endif
    ex.push_back(w(LO, v[31:0]));
    ex.push_back(w(HI, v[63:32]));
  endfunction

  task automatic tick();
    logic [NT-1:0] na = m_armed;
    logic [NT-1:0] ne = m_exp;
    logic [63:0]   nd [NT];
    nd = m_dl;
    if (!rst_n) begin
      na = '0;
      ne = '0;
      for (int i = 0; i < NT; i++) nd[i] = '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        bit tgt = cfg_valid && (cfg_id == 2'(i));
        bit due = m_armed[i] && (mtime >= m_dl[i]) && !tgt;
        if (tgt) begin
          na[i] = (cfg_op == 1'b0);
          if (cfg_op == 1'b0) nd[i] = cfg_dl;
        end else if (due) begin
          na[i] = 1'b0;
        end
        if (due) ne[i] = 1'b1;
        else if (exp_ack[i]) ne[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_armed = na;
    m_exp   = ne;
    m_dl    = nd;
    chk("expired", 64'(expired), 64'(m_exp));
    chk("irq", 64'(irq), 64'(|m_exp));
  endtask

  task automatic cmd(logic op, logic [1:0] id, logic [63:0] dl);
    cfg_valid = 1'b1;
    cfg_op    = op;
    cfg_id    = id;
    cfg_dl    = dl;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic settle(int n);
    for (int k = 0; k < n; k++) tick();
    chk("settle_busy", 64'(busy), 64'd0);
  endtask

  task automatic chk_log(string name, int mark);
    chk({name, "_count"}, 64'(wlog.size() - mark), 64'(ex.size()));
    for (int k = 0; k < ex.size() && mark + k < wlog.size(); k++) begin
      chk($sformatf("%s_adr%0d", name, k), 64'(wlog[mark+k].adr), 64'(ex[k].adr));
      chk($sformatf("%s_dat%0d", name, k), 64'(wlog[mark+k].dat), 64'(ex[k].dat));
      chk($sformatf("%s_we%0d", name, k), 64'(wlog[mark+k].we), 64'(ex[k].we));
      chk($sformatf("%s_sel%0d", name, k), 64'(wlog[mark+k].sel), 64'(ex[k].sel));
    end
  endtask

  function automatic step_t s(bit v, bit op, int id, int dl, int mt, int a, int e);
    return '{v, op, 2'(id), 64'(dl), 64'(mt), 4'(a), 4'(e)};
  endfunction

  step_t tbl [14];
  int    mark, cmark, nb;

  initial begin
    for (int i = 0; i < NT; i++) m_dl[i] = '0;

    tbl[0]  = s(1, 0, 1, 200, 100, 0, 4'b0000);
    tbl[1]  = s(1, 0, 0, 150, 100, 0, 4'b0000);
    tbl[2]  = s(0, 0, 0, 0,   150, 0, 4'b0001);
    tbl[3]  = s(0, 0, 0, 0,   200, 4'b0010, 4'b0011);
    tbl[4]  = s(0, 0, 0, 0,   200, 4'b0011, 4'b0000);
    tbl[5]  = s(1, 0, 3, 50,  200, 0, 4'b0000);
    tbl[6]  = s(0, 0, 0, 0,   200, 0, 4'b1000);
    tbl[7]  = s(1, 0, 3, 300, 200, 0, 4'b1000);
    tbl[8]  = s(1, 0, 3, 10,  400, 0, 4'b1000);
    tbl[9]  = s(0, 0, 0, 0,   400, 4'b1000, 4'b1000);
    tbl[10] = s(0, 0, 0, 0,   400, 4'b1000, 4'b0000);
    tbl[11] = s(1, 0, 2, 500, 400, 0, 4'b0000);
    tbl[12] = s(1, 1, 2, 0,   600, 0, 4'b0000);
    tbl[13] = s(0, 0, 0, 0,   600, 0, 4'b0000);

    // Reset values, then an idle stretch with no bus traffic.
    repeat (3) tick();
    chk("rst_adr", 64'(adr), 64'd0);
    chk("rst_dat", 64'(dat), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_cyc", 64'(cyc), 64'd0);
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    mtime = 64'd10;
    repeat (50) tick();
    chk("idle_cyc", 64'(cyc_cycles), 64'd0);
    chk("idle_writes", 64'(wlog.size()), 64'd0);

    // ARM slot 2 at 100: strobe timing, write order, expiry edge.
    mark = wlog.size();
    cmd(1'b0, 2'd2, 64'd100);
    chk("t1_cyc_early", 64'(cyc), 64'd0);
    tick();
    chk("t1_cyc_rise", 64'(cyc), 64'd1);
    nb = 1;
    for (int k = 0; k < 40 && busy; k++) begin
      tick();
      if (busy) nb++;
    end
`ifdef TIMER_MUX_SAFE_UPDATE_EN
    chk("t1_busy_len", 64'(nb), 64'd5);
`else
    chk("t1_busy_len", 64'(nb), 64'd3);
`endif
    ex = '{};
    push_seq(64'd100);
    chk_log("t1_log", mark);
    mtime = 64'd99;
    tick();
    chk("t1_exp99", 64'(expired), 64'd0);
    mtime = 64'd100;
    tick();
    chk("t1_exp100", 64'(expired), 64'h4);
    chk("t1_irq", 64'(irq), 64'd1);
    exp_ack = 4'b0100;
    tick();
    exp_ack = '0;
    chk("t1_ack", 64'(expired), 64'd0);
    settle(30);
    chk("t1_clint", {clint_hi, clint_lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Expiry/command/ack precedence table.
    for (int k = 0; k < 14; k++) begin
      cfg_valid = tbl[k].v;
      cfg_op    = tbl[k].op;
      cfg_id    = tbl[k].id;
      cfg_dl    = tbl[k].dl;
      mtime     = tbl[k].mt;
      exp_ack   = tbl[k].ack;
      tick();
      chk($sformatf("tbl%0d", k), 64'(expired), 64'(tbl[k].ex));
    end
    cfg_valid = 1'b0;
    exp_ack   = '0;
    settle(30);
    chk("t2_clint", {clint_hi, clint_lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // New earlier deadline mid-sequence: finish 500, then program 300.
    mtime = 64'd10;
    mark  = wlog.size();
    cmd(1'b0, 2'd0, 64'd500);
    tick();
    chk("t3_inflight", 64'(cyc), 64'd1);
    cmd(1'b0, 2'd1, 64'd300);
    settle(40);
    ex = '{};
    push_seq(64'd500);
    push_seq(64'd300);
    chk_log("t3_log", mark);
    chk("t3_clint", {clint_hi, clint_lo}, 64'd300);

    // Cancel non-minimum slot (no traffic), then the only armed slot.
    mark = wlog.size();
    cmd(1'b1, 2'd0, 64'd0);
    settle(20);
    ex = '{};
    chk_log("t4a_log", mark);
    mark = wlog.size();
    cmd(1'b1, 2'd1, 64'd0);
    settle(30);
    push_seq(64'hFFFF_FFFF_FFFF_FFFF);
    chk_log("t4b_log", mark);

    // Slave with 3 wait states on every write.
    lat   = 3;
    mark  = wlog.size();
    cmark = cyc_cycles;
    cmd(1'b0, 2'd0, 64'h0000_0001_0000_0123);
    tick();
    nb = 1;
    for (int k = 0; k < 60 && busy; k++) begin
      tick();
      if (busy) nb++;
    end
`ifdef TIMER_MUX_SAFE_UPDATE_EN
    chk("t5_busy_len", 64'(nb), 64'd14);
    chk("t5_stb_len", 64'(cyc_cycles - cmark), 64'd12);
`else
    chk("t5_busy_len", 64'(nb), 64'd9);
    chk("t5_stb_len", 64'(cyc_cycles - cmark), 64'd8);
`endif
    ex = '{};
    push_seq(64'h0000_0001_0000_0123);
    chk_log("t5_log", mark);
    lat = 0;
    cmd(1'b1, 2'd0, 64'd0);
    settle(30);

    // Reset while the lo write is on the bus.
    lat = 3;
    cmd(1'b0, 2'd1, 64'd777);
    for (int k = 0; k < 20 && !(cyc && adr == LO); k++) tick();
    chk("t6_reach_lo", 64'(cyc && adr == LO), 64'd1);
    mark  = wlog.size();
    rst_n = 1'b0;
    tick();
    chk("t6_cyc", 64'(cyc), 64'd0);
    chk("t6_stb", 64'(stb), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    lat   = 0;
    cmark = cyc_cycles;
    repeat (20) tick();
    chk("t6_quiet_cyc", 64'(cyc_cycles - cmark), 64'd0);
    chk("t6_quiet_log", 64'(wlog.size() - mark), 64'd0);

    // Random commands and acks against the reference model.
    mtime = 64'h0000_0001_FFFF_FF00;
    for (int r = 0; r < 6; r++) begin
      lat = $urandom_range(0, 3);
      for (int c = 0; c < 80; c++) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        cfg_op    = ($urandom_range(0, 3) == 0);
        cfg_id    = 2'($urandom_range(0, NT - 1));
        cfg_dl    = mtime + 64'($urandom_range(0, 120)) - 64'd20;
        exp_ack   = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        tick();
        mtime = mtime + 64'($urandom_range(0, 2));
      end
      cfg_valid = 1'b0;
      exp_ack   = '0;
      settle(80);
      chk($sformatf("rnd%0d_clint", r), {clint_hi, clint_lo}, m_target());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
